tone_synth_recorder: RTL and testbench
======================================

// Module: tone_synth_recorder
// PURPOSE
//  Parametrised key-to-tone synthesiser with a programmable note table and a
//  1-bit sample record/playback buffer. Sits between the keyboard scanner and
//  the speaker pin. Replaces fixed-frequency note decoding with a runtime-loaded
//  half-period table. Adds defined key priority, glitch-free note changes and
//  sample-rate-timed record/playback.
// PARAMETERS
//  NUM_KEYS   11    number of key inputs / note-table entries
//  CNT_W      24    width of half-period values and tone counter
//  REC_DEPTH  128   recording buffer depth in 1-bit samples
//  SAMPLE_DIV 1000  clk cycles per record/playback sample tick (>=1)
//  REC_WRAP   0     0: stop recording at REC_DEPTH; 1: overwrite circularly until rec_stop
//  IDX_W = clog2(NUM_KEYS), PTR_W = clog2(REC_DEPTH+1) (localparams)
// PORTS
//  clk        in   1         system clock; all logic on posedge
//  rst        in   1         synchronous, active-high reset
//  keys       in   NUM_KEYS  key levels, bit i = note i
//  cfg_we     in   1         note-table write strobe
//  cfg_idx    in   IDX_W     note-table entry to write
//  cfg_half   in   CNT_W     half-period in clk cycles (0 = muted)
//  rec_start  in   1         pulse: begin recording
//  rec_stop   in   1         pulse: end recording
//  play_start in   1         pulse: begin playback
//  sound      out  1         speaker output
//  key_valid  out  1         a key is selected
//  key_idx    out  IDX_W     selected key index
//  rec_busy   out  1         recording in progress
//  rec_full   out  1         buffer filled (REC_WRAP=0) or has wrapped (REC_WRAP=1)
//  rec_count  out  PTR_W     valid samples in buffer, saturates at REC_DEPTH
//  play_busy  out  1         playback in progress
// BEHAVIOUR
//  Reset: all outputs 0; table entries 0; tone counter 0; tick divider 0; pointers 0.
//  Key select: keys registered once. Lowest set bit wins.
//   - key_idx/key_valid update 2 cycles after a keys change.
//   - No bit set -> key_valid=0, key_idx=0.
//  Table: cfg_we writes cfg_half to entry cfg_idx at the edge. cfg_idx>=NUM_KEYS is ignored.
//  Tone: tone=0 and cnt=0 while !key_valid or half==0 (half = table[key_idx]).
//   - Otherwise cnt increments each cycle. At cnt==half-1: cnt<=0 and tone toggles.
//   - Period is 2*half cycles; half==1 toggles tone every cycle.
//   - On a key_idx/key_valid change, or a write to the selected entry:
//     cnt<=0 and tone<=0 on the next edge, then counting restarts.
//  Tick: free-running divider; one-cycle tick every SAMPLE_DIV clks, first at cycle SAMPLE_DIV after rst.
//  Record (IDLE->REC):
//   - rec_start while neither busy: rec_busy=1, wr_ptr=0, rec_count=0, rec_full=0.
//   - On each tick while rec_busy: mem[wr_ptr]<=tone, wr_ptr++, rec_count++ (saturating).
//   - REC_WRAP=0: after sample REC_DEPTH is stored, rec_busy<=0 and rec_full<=1.
//   - REC_WRAP=1: wr_ptr wraps to 0, rec_full<=1, recording continues.
//   - rec_stop clears rec_busy next edge; a tick in the same cycle is still stored.
//  Playback (IDLE->PLAY):
//   - play_start while idle and rec_count>0: play_busy=1, rd_ptr=0.
//   - With REC_WRAP=1 and rec_full=1, rd_ptr starts at wr_ptr (oldest sample).
//   - On each tick: play_bit<=mem[rd_ptr], rd_ptr++ (mod REC_DEPTH).
//   - After rec_count ticks, play_busy<=0 and play_bit<=0.
//  Arbitration:
//   - rec_start and play_start in the same idle cycle: record wins.
//   - Either start while any busy: ignored.
//   - rec_stop while idle: ignored.
//  Output: sound = play_busy ? play_bit : tone, registered (one cycle after tone/play_bit).
//  Reset mid-operation: rst aborts REC/PLAY; buffer contents become undefined.
// TESTING
//  1. rst, table[2]=3, keys=0b100 -> key_valid=1, key_idx=2 after 2 clk; sound period 6 clk, 50% duty.
//  2. keys=0b0110 with table[1]=5, table[2]=3 -> key_idx=1, period 10; then keys=0 -> sound 0, key_valid 0.
//  3. Play key 2 (half=3), switch to key 0 (half=7) mid-high-phase -> sound 0 within 2 clk of key_idx change, then period 14 from 0.
//  4. SAMPLE_DIV=4, REC_DEPTH=8, REC_WRAP=0, rec_start -> rec_busy drops after 8 ticks (32 clk), rec_full=1, rec_count=8.
//  5. Then play_start -> play_busy for 8 ticks, sound reproduces the stored 8 bits; play_start during REC ignored.
//  6. REC_WRAP=1, record 11 ticks then rec_stop -> rec_count=8, rec_full=1; playback returns samples 3..10 in order.

Source files
------------

// File: rtl/tone_synth_recorder.sv
// Key-to-tone synthesiser with a runtime-loaded half-period table and a 1-bit
// sample record/playback buffer driving the speaker pin.
module tone_synth_recorder #(
  parameter int NUM_KEYS   = 11,
  parameter int CNT_W      = 24,
  parameter int REC_DEPTH  = 128,
  parameter int SAMPLE_DIV = 1000,
  parameter int REC_WRAP   = 0,
  localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
  localparam int PTR_W = $clog2(REC_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic [CNT_W-1:0]    cfg_half,
  input  logic                rec_start,
  input  logic                rec_stop,
  input  logic                play_start,
  output logic                sound,
  output logic                key_valid,
  output logic [IDX_W-1:0]    key_idx,
  output logic                rec_busy,
  output logic                rec_full,
  output logic [PTR_W-1:0]    rec_count,
  output logic                play_busy
);

  localparam int AW    = (REC_DEPTH > 1) ? $clog2(REC_DEPTH) : 1;
  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  localparam logic [IDX_W:0]   KEY_LIM  = (IDX_W+1)'(NUM_KEYS);
  localparam logic [AW-1:0]    WR_LAST  = AW'(REC_DEPTH - 1);
  localparam logic [PTR_W-1:0] CNT_MAX  = PTR_W'(REC_DEPTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  typedef enum logic [1:0] {IDLE, REC, PLAY} state_t;

  logic [NUM_KEYS-1:0] keys_q;
  logic [IDX_W-1:0]    sel_idx;
  logic                sel_valid;
  logic [IDX_W-1:0]    key_idx_d;
  logic                key_valid_d;
  logic [CNT_W-1:0]    note_tbl [NUM_KEYS];
  logic [CNT_W-1:0]    half;
  logic [CNT_W-1:0]    cnt;
  logic                tone;
  logic                cfg_ok;
  logic                sel_write;
  logic                restart;
  logic [DIV_W-1:0]    div;
  logic                tick;
  state_t              state;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [PTR_W-1:0]    play_left;
  logic                play_bit;
  logic [REC_DEPTH-1:0] mem;

  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (!sel_valid && keys_q[i]) begin
        sel_valid = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      keys_q      <= '0;
      key_idx     <= '0;
      key_valid   <= 1'b0;
      key_idx_d   <= '0;
      key_valid_d <= 1'b0;
    end else begin
      keys_q      <= keys;
      key_idx     <= sel_idx;
      key_valid   <= sel_valid;
      key_idx_d   <= key_idx;
      key_valid_d <= key_valid;
    end
  end

  assign cfg_ok = {1'b0, cfg_idx} < KEY_LIM;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_KEYS; i++) note_tbl[i] <= '0;
    end else if (cfg_we && cfg_ok) begin
      note_tbl[cfg_idx] <= cfg_half;
    end
  end

  assign half      = note_tbl[key_idx];
  assign sel_write = cfg_we && cfg_ok && key_valid && (cfg_idx == key_idx);
  // A selection change is seen one cycle late via the _d copies, so the restart lands on the following edge.
  assign restart   = sel_write || (key_idx != key_idx_d) || (key_valid != key_valid_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (!key_valid || (half == '0) || restart) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (cnt == half - CNT_W'(1)) begin
      cnt  <= '0;
      tone <= ~tone;
    end else begin
      cnt  <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (div == DIV_LAST);
      div  <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (state == REC && tick) mem[wr_ptr] <= tone;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rec_busy  <= 1'b0;
      rec_full  <= 1'b0;
      rec_count <= '0;
      play_busy <= 1'b0;
      play_bit  <= 1'b0;
      play_left <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rec_start) begin
            state     <= REC;
            rec_busy  <= 1'b1;
            rec_full  <= 1'b0;
            rec_count <= '0;
            wr_ptr    <= '0;
          end else if (play_start && (rec_count != '0)) begin
            state     <= PLAY;
            play_busy <= 1'b1;
            play_bit  <= 1'b0;
            play_left <= rec_count;
            rd_ptr    <= ((REC_WRAP != 0) && rec_full) ? wr_ptr : '0;
          end
        end
        REC: begin
          if (tick) begin
            if (rec_count != CNT_MAX) rec_count <= rec_count + PTR_W'(1);
            wr_ptr <= (wr_ptr == WR_LAST) ? '0 : wr_ptr + AW'(1);
            if (wr_ptr == WR_LAST) begin
              rec_full <= 1'b1;
              if (REC_WRAP == 0) begin
                state    <= IDLE;
                rec_busy <= 1'b0;
              end
            end
          end
          if (rec_stop) begin
            state    <= IDLE;
            rec_busy <= 1'b0;
          end
        end
        PLAY: begin
          if (tick) begin
            if (play_left == '0) begin
              state     <= IDLE;
              play_busy <= 1'b0;
              play_bit  <= 1'b0;
            end else begin
              play_bit  <= mem[rd_ptr];
              rd_ptr    <= (rd_ptr == WR_LAST) ? '0 : rd_ptr + AW'(1);
              play_left <= play_left - PTR_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) sound <= 1'b0;
    else     sound <= play_busy ? play_bit : tone;
  end

endmodule

// File: tb/tb_tone_synth_recorder.sv
// Scoreboard bench: two recorders (stop-at-depth and circular) share the keyboard
// and note table; expectations are queued with target cycles and checked on negedge.
module tb_tone_synth_recorder;

  localparam int NK = 11;
  localparam int CW = 24;
  localparam int DEPTH = 8;
  localparam int DIV = 4;
  localparam int IW = 4;
  localparam int PW = 4;
  localparam int C0 = 3;   // last cycle with reset asserted
  localparam int TA = 100; // edge where the key-1 tone first goes high
  localparam int TH = 5;   // key-1 half period

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] keys = '0;
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic [CW-1:0] cfg_half = '0;
  logic          rec_start0 = 1'b0, rec_stop0 = 1'b0, play_start0 = 1'b0;
  logic          rec_start1 = 1'b0, rec_stop1 = 1'b0, play_start1 = 1'b0;
  logic          sound0, key_valid0, rec_busy0, rec_full0, play_busy0;
  logic          sound1, key_valid1, rec_busy1, rec_full1, play_busy1;
  logic [IW-1:0] key_idx0, key_idx1;
  logic [PW-1:0] rec_count0, rec_count1;

  tone_synth_recorder #(.NUM_KEYS(NK), .CNT_W(CW), .REC_DEPTH(DEPTH), .SAMPLE_DIV(DIV), .REC_WRAP(0)) dut0 (
    .clk(clk), .rst(rst), .keys(keys), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_half(cfg_half),
    .rec_start(rec_start0), .rec_stop(rec_stop0), .play_start(play_start0),
    .sound(sound0), .key_valid(key_valid0), .key_idx(key_idx0), .rec_busy(rec_busy0),
    .rec_full(rec_full0), .rec_count(rec_count0), .play_busy(play_busy0));

  tone_synth_recorder #(.NUM_KEYS(NK), .CNT_W(CW), .REC_DEPTH(DEPTH), .SAMPLE_DIV(DIV), .REC_WRAP(1)) dut1 (
    .clk(clk), .rst(rst), .keys(keys), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_half(cfg_half),
    .rec_start(rec_start1), .rec_stop(rec_stop1), .play_start(play_start1),
    .sound(sound1), .key_valid(key_valid1), .key_idx(key_idx1), .rec_busy(rec_busy1),
    .rec_full(rec_full1), .rec_count(rec_count1), .play_busy(play_busy1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int sig;
    int val;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // signal ids: 0..6 dut0, 8..14 dut1
  localparam int S_SND = 0, S_KV = 1, S_KI = 2, S_RB = 3, S_RF = 4, S_RC = 5, S_PB = 6;

  function automatic int get_sig(int s);
    case (s)
      0: return int'(sound0);
      1: return int'(key_valid0);
      2: return int'(key_idx0);
      3: return int'(rec_busy0);
      4: return int'(rec_full0);
      5: return int'(rec_count0);
      6: return int'(play_busy0);
      8: return int'(sound1);
      9: return int'(key_valid1);
      10: return int'(key_idx1);
      11: return int'(rec_busy1);
      12: return int'(rec_full1);
      13: return int'(rec_count1);
      14: return int'(play_busy1);
      default: return -1;
    endcase
  endfunction

  function automatic string sig_name(int s);
    string base;
    case (s % 8)
      0: base = "sound";
      1: base = "key_valid";
      2: base = "key_idx";
      3: base = "rec_busy";
      4: base = "rec_full";
      5: base = "rec_count";
      6: base = "play_busy";
      default: base = "unknown";
    endcase
    return $sformatf("%s%0d", base, s / 8);
  endfunction

  task automatic expect_at(input int c, input int s, input int v);
    exp_t e;
    e.cyc = c;
    e.sig = s;
    e.val = v;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t keep[$];
    int got;
    keep = {};
    foreach (sb[i]) begin
      if (sb[i].cyc == cyc) begin
        got = get_sig(sb[i].sig);
        checks++;
        if (got != sb[i].val) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%0d exp=%0d", sig_name(sb[i].sig), cyc, got, sb[i].val);
        end
      end else if (sb[i].cyc < cyc) begin
        errors++;
        $display("FAIL %s cyc=%0d not sampled got=none exp=%0d", sig_name(sb[i].sig), sb[i].cyc, sb[i].val);
      end else begin
        keep.push_back(sb[i]);
      end
    end
    sb = keep;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step(1);
  endtask

  function automatic int tone_at(input int x);
    if (x < TA) return 0;
    return (((x - TA) / TH) % 2 == 0) ? 1 : 0;
  endfunction

  function automatic int next_tick(input int c);
    int t;
    t = c;
    while ((t - C0 - 1) % DIV != 0) t++;
    return t;
  endfunction

  int r0[8];
  int s1[11];
  int t0, u0, w1, u1;

  initial begin
    for (int s = 0; s < 7; s++) begin
      expect_at(C0, s, 0);
      expect_at(C0, s + 8, 0);
    end
    goto(C0);
    rst = 1'b0;

    // key 2, half 3; entries 1 and 0 loaded in the following cycles
    cfg_we = 1'b1; cfg_idx = 4'd2; cfg_half = 24'd3; keys = 11'b100;
    expect_at(4, S_KV, 0);
    expect_at(5, S_KV, 1);
    expect_at(5, S_KI, 2);
    expect_at(9, S_SND, 0);
    expect_at(10, S_SND, 1);
    expect_at(12, S_SND, 1);
    expect_at(13, S_SND, 0);
    expect_at(15, S_SND, 0);
    expect_at(16, S_SND, 1);
    expect_at(18, S_SND, 1);
    expect_at(19, S_SND, 0);
    expect_at(19, S_SND + 8, 0);
    step(1);
    cfg_idx = 4'd1; cfg_half = 24'd5;
    step(1);
    cfg_idx = 4'd0; cfg_half = 24'd7;
    step(1);
    cfg_we = 1'b0;

    goto(10);
    play_start1 = 1'b1;
    expect_at(11, S_PB + 8, 0);
    expect_at(12, S_PB + 8, 0);
    step(1);
    play_start1 = 1'b0;

    goto(20);
    keys = '0;

    // keys 1 and 2 both pressed: lowest bit wins
    goto(30);
    keys = 11'b110;
    expect_at(31, S_KV, 0);
    expect_at(32, S_KV, 1);
    expect_at(32, S_KI, 1);
    expect_at(38, S_SND, 0);
    expect_at(39, S_SND, 1);
    expect_at(43, S_SND, 1);
    expect_at(44, S_SND, 0);
    expect_at(48, S_SND, 0);
    expect_at(49, S_SND, 1);
    goto(50);
    keys = '0;
    expect_at(52, S_KV, 0);
    expect_at(52, S_KI, 0);
    expect_at(54, S_SND, 0);
    expect_at(56, S_SND, 0);

    // switch from key 2 to key 0 during the high phase
    goto(60);
    keys = 11'b100;
    expect_at(62, S_KI, 2);
    goto(65);
    keys = 11'b101;
    expect_at(67, S_KI, 0);
    expect_at(67, S_KV, 1);
    expect_at(68, S_SND, 1);
    expect_at(69, S_SND, 0);
    expect_at(75, S_SND, 0);
    expect_at(76, S_SND, 1);
    expect_at(82, S_SND, 1);
    expect_at(83, S_SND, 0);
    expect_at(89, S_SND, 0);
    expect_at(90, S_SND, 1);

    // key 1 (half 5) is the recorded source from here on
    goto(92);
    keys = 11'b010;

    goto(102);
    rec_start0 = 1'b1;
    expect_at(103, S_RB, 1);
    expect_at(103, S_RC, 0);
    expect_at(103, S_RF, 0);
    t0 = next_tick(104);
    for (int i = 0; i < 8; i++) r0[i] = tone_at(t0 + DIV * i - 1);
    expect_at(t0 + 7 * DIV - 1, S_RB, 1);
    expect_at(t0 + 7 * DIV - 1, S_RC, 7);
    expect_at(t0 + 7 * DIV, S_RB, 0);
    expect_at(t0 + 7 * DIV, S_RF, 1);
    expect_at(t0 + 7 * DIV, S_RC, 8);
    step(1);
    rec_start0 = 1'b0;

    goto(110);
    play_start0 = 1'b1;
    expect_at(111, S_PB, 0);
    expect_at(112, S_PB, 0);
    step(1);
    play_start0 = 1'b0;

    goto(t0 + 7 * DIV + 2);
    play_start0 = 1'b1;
    expect_at(cyc + 1, S_PB, 1);
    u0 = next_tick(cyc + 2);
    expect_at(u0, S_SND, 0);
    for (int j = 0; j < 8; j++) begin
      expect_at(u0 + DIV * j + 1, S_SND, r0[j]);
      expect_at(u0 + DIV * j + DIV, S_SND, r0[j]);
    end
    expect_at(u0 + 8 * DIV - 1, S_PB, 1);
    expect_at(u0 + 8 * DIV, S_PB, 0);
    expect_at(u0 + 8 * DIV, S_RC, 8);
    step(1);
    play_start0 = 1'b0;

    // simultaneous starts while idle: record wins
    goto(u0 + 8 * DIV + 4);
    rec_start0 = 1'b1;
    play_start0 = 1'b1;
    expect_at(cyc + 1, S_RB, 1);
    expect_at(cyc + 1, S_PB, 0);
    expect_at(cyc + 1, S_RC, 0);
    expect_at(cyc + 1, S_RF, 0);
    step(1);
    rec_start0 = 1'b0;
    play_start0 = 1'b0;
    rec_stop0 = 1'b1;
    expect_at(cyc + 1, S_RB, 0);
    expect_at(cyc + 1, S_PB, 0);
    step(1);
    rec_stop0 = 1'b0;

    // circular recorder: 11 ticks, stop coincides with the 11th tick
    goto(cyc + 6);
    rec_start1 = 1'b1;
    expect_at(cyc + 1, S_RB + 8, 1);
    expect_at(cyc + 1, S_RF + 8, 0);
    w1 = next_tick(cyc + 2);
    for (int i = 0; i < 11; i++) s1[i] = tone_at(w1 + DIV * i - 1);
    expect_at(w1 + 7 * DIV - 1, S_RC + 8, 7);
    expect_at(w1 + 7 * DIV - 1, S_RF + 8, 0);
    expect_at(w1 + 7 * DIV, S_RC + 8, 8);
    expect_at(w1 + 7 * DIV, S_RF + 8, 1);
    expect_at(w1 + 7 * DIV, S_RB + 8, 1);
    expect_at(w1 + 10 * DIV, S_RB + 8, 0);
    expect_at(w1 + 10 * DIV, S_RC + 8, 8);
    expect_at(w1 + 10 * DIV, S_RF + 8, 1);
    step(1);
    rec_start1 = 1'b0;
    goto(w1 + 10 * DIV - 1);
    rec_stop1 = 1'b1;
    step(1);
    rec_stop1 = 1'b0;

    goto(w1 + 10 * DIV + 4);
    play_start1 = 1'b1;
    expect_at(cyc + 1, S_PB + 8, 1);
    u1 = next_tick(cyc + 2);
    for (int j = 0; j < 8; j++) begin
      expect_at(u1 + DIV * j + 1, S_SND + 8, s1[j + 3]);
      expect_at(u1 + DIV * j + DIV, S_SND + 8, s1[j + 3]);
    end
    expect_at(u1 + 8 * DIV, S_PB + 8, 0);
    step(1);
    play_start1 = 1'b0;

    for (int k = 0; k < 200 && sb.size() != 0; k++) step(1);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
